// File: rtl/instr_encoder_loader.sv
// ============================================================================
// instr_encoder_loader
//
// Purpose:
//   Turns simple instruction requests (R-ALU, I-ALU, LW, SW, BEQ, END) into
//   32-bit RV32I machine words. Each word is written into an instruction
//   memory at BASE_ADDR + 4*count. A request is accepted in IDLE. The encoded
//   word is written in the following cycle (WRITE). DONE is entered when the
//   memory is full or an END request is accepted. DONE is held until reset.
//
// Parameters:
//   BASE_ADDR   byte address of the first instruction-memory write
//   MAX_WORDS   capacity in words (1..255)
//
// Build option:
//   ENCODER_HALT_WORD_EN  when defined, END writes the halt word 32'h0000_0063
//                         (beq x0,x0,0) before entering DONE. When undefined,
//                         END goes straight to DONE and writes nothing.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   req_valid/ready   request handshake (accept = req_valid & req_ready)
//   req_kind          0=R-ALU 1=I-ALU 2=LW 3=SW 4=BEQ 5=END (6,7 illegal)
//   req_funct3        ALU funct3
//   req_funct7b5      ALU funct7 bit 5
//   req_rd/rs1/rs2    register indices
//   req_imm           signed immediate ([11:0] for I/LW/SW, [12:0] for BEQ)
//   imem_we/addr/wdata  instruction-memory write port (byte address)
//   done, full, err   status flags (err is sticky)
//   count             number of words written so far
// ============================================================================
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7b5,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [12:0] req_imm,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        done,
    output logic        full,
    output logic        err,
    output logic [7:0]  count
);

    localparam logic [7:0] MAX_COUNT = 8'(MAX_WORDS);

    localparam logic [2:0] KIND_R   = 3'd0;
    localparam logic [2:0] KIND_I   = 3'd1;
    localparam logic [2:0] KIND_LW  = 3'd2;
    localparam logic [2:0] KIND_SW  = 3'd3;
    localparam logic [2:0] KIND_BEQ = 3'd4;
    localparam logic [2:0] KIND_END = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        is_end;
    logic        accept;
    logic        takes_write;
    logic [7:0]  count_next;

`ifdef ENCODER_HALT_WORD_EN
    // Set while the word in flight is the halt word: its WRITE always ends in DONE.
    logic        halt_pending;
`endif

    // ------------------------------------------------------------------
    // Encoder: combinational RV32I word from the current request fields.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        is_end    = 1'b0;
        unique case (req_kind)
            KIND_R:   enc_word = {1'b0, req_funct7b5, 5'b0, req_rs2, req_rs1,
                                  req_funct3, req_rd, 7'b0110011};
            KIND_I:   enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd,
                                  7'b0010011};
            KIND_LW:  enc_word = {req_imm[11:0], req_rs1, 3'b010, req_rd,
                                  7'b0000011};
            KIND_SW:  enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010,
                                  req_imm[4:0], 7'b0100011};
            KIND_BEQ: begin
                enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                             3'b000, req_imm[4:1], req_imm[11], 7'b1100011};
                // Branch offsets are in halfwords; an odd byte offset cannot be encoded.
                enc_legal = ~req_imm[0];
            end
            KIND_END: begin
                enc_word = 32'h0000_0063;
                is_end   = 1'b1;
            end
            default:  enc_legal = 1'b0;
        endcase
    end

    assign accept     = req_valid & req_ready;
    assign count_next = count + 8'd1;

`ifdef ENCODER_HALT_WORD_EN
    // END is written like any other word.
    assign takes_write = enc_legal;
`else
    // END skips the write and goes straight to DONE.
    assign takes_write = enc_legal & ~is_end;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        imem_we    = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (takes_write)             state_next = WRITE;
                    else if (enc_legal && is_end) state_next = DONE;
                end
            end
            WRITE: begin
                imem_we = 1'b1;
`ifdef ENCODER_HALT_WORD_EN
                if (count_next == MAX_COUNT || halt_pending) state_next = DONE;
`else
                if (count_next == MAX_COUNT) state_next = DONE;
`endif
                else state_next = IDLE;
            end
            DONE: done = 1'b1;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and status registers.
    // The address and data are loaded at accept time. They are therefore
    // valid for the whole WRITE cycle and hold afterwards while imem_we=0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'h0000_0000;
            count        <= 8'd0;
            full         <= 1'b0;
            err          <= 1'b0;
`ifdef ENCODER_HALT_WORD_EN
            halt_pending <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register sees the pre-edge values of the others.
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (!enc_legal) begin
                            err <= 1'b1;
                        end else if (takes_write) begin
                            imem_wdata   <= enc_word;
                            imem_addr    <= BASE_ADDR + {22'd0, count, 2'b00};
`ifdef ENCODER_HALT_WORD_EN
                            halt_pending <= is_end;
`endif
                        end
                    end
                end
                WRITE: begin
                    count <= count_next;
                    if (count_next == MAX_COUNT) full <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// tb_instr_encoder_loader
//
// Directed self-checking bench for instr_encoder_loader.
// dut:  default parameters (BASE_ADDR=0, MAX_WORDS=64).
// dut2: MAX_WORDS=2, with its own req_valid, for the capacity check.
// The END check follows ENCODER_HALT_WORD_EN, matching the RTL build.
// ============================================================================
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_valid2;
    logic [2:0]  req_kind;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [12:0] req_imm;

    logic        req_ready, imem_we, done, full, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [7:0]  count;

    logic        req_ready2, imem_we2, done2, full2, err2;
    logic [31:0] imem_addr2, imem_wdata2;
    logic [7:0]  count2;

    int errors = 0;
    int checks = 0;
    int writes2 = 0;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .full(full), .err(err), .count(count)
    );

    instr_encoder_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_kind(req_kind), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .done(done2), .full(full2), .err(err2), .count(count2)
    );

    // Count dut2 write pulses mid-cycle, away from the active edge.
    always @(negedge clk) if (imem_we2) writes2++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge. Returns 1 time unit after that edge.
    task automatic send(input logic [2:0] kind, input logic [2:0] f3, input logic f7b5,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [12:0] imm);
        @(negedge clk);
        req_kind = kind; req_funct3 = f3; req_funct7b5 = f7b5;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0;
        req_kind = 3'd0; req_funct3 = 3'd0; req_funct7b5 = 1'b0;
        req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 13'd0;

        // Reset state.
        #3;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_we",    {31'd0, imem_we},   32'd0);
        check("rst_addr",  imem_addr,          32'h0);
        check("rst_wdata", imem_wdata,         32'h0);
        check("rst_count", {24'd0, count},     32'd0);
        check("rst_flags", {29'd0, done, full, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-ALU: add then sub.
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
        check("add_we",    {31'd0, imem_we},   32'd1);
        check("add_ready", {31'd0, req_ready}, 32'd0);
        check("add_addr",  imem_addr,          32'h0);
        check("add_wdata", imem_wdata,         32'h002081B3);
        tick();
        check("add_we_off", {31'd0, imem_we},  32'd0);
        check("add_hold",   imem_wdata,        32'h002081B3);
        check("add_count",  {24'd0, count},    32'd1);
        send(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 13'd0);
        check("sub_addr",  imem_addr,          32'h4);
        check("sub_wdata", imem_wdata,         32'h402081B3);
        tick();

        // LW / SW from a fresh start.
        pulse_reset();
        send(3'd2, 3'd7, 1'b0, 5'd5, 5'd0, 5'd0, 13'd8);
        check("lw_wdata", imem_wdata, 32'h00802283);
        check("lw_addr",  imem_addr,  32'h0);
        tick();
        send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd5, 13'd4);
        check("sw_wdata", imem_wdata, 32'h0050A223);
        check("sw_addr",  imem_addr,  32'h4);
        tick();
        check("sw_count", {24'd0, count}, 32'd2);

        // BEQ with -4, then misaligned BEQ.
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'h1FFC);
        check("beq_wdata", imem_wdata, 32'hFE208EE3);
        check("beq_addr",  imem_addr,  32'h8);
        tick();
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 13'd3);
        check("beq_odd_err",   {31'd0, err},       32'd1);
        check("beq_odd_we",    {31'd0, imem_we},   32'd0);
        check("beq_odd_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("beq_odd_count", {24'd0, count},     32'd3);

        // Illegal kind 7 keeps err and writes nothing.
        send(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
        check("ill_we",    {31'd0, imem_we},   32'd0);
        check("ill_count", {24'd0, count},     32'd3);

        // Request held during WRITE (illegal kind) must be ignored.
        pulse_reset();
        check("err_cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        req_kind = 3'd2; req_rd = 5'd1; req_rs1 = 5'd0; req_imm = 13'd0;
        req_valid = 1'b1;
        tick();
        check("hold_we", {31'd0, imem_we}, 32'd1);
        req_kind = 3'd6;
        tick();
        req_valid = 1'b0;
        check("hold_err",   {31'd0, err},       32'd0);
        check("hold_count", {24'd0, count},     32'd1);
        check("hold_ready", {31'd0, req_ready}, 32'd1);

        // Reset pulsed in the WRITE cycle aborts the write.
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
        check("abort_pre_we", {31'd0, imem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_we",    {31'd0, imem_we},   32'd0);
        check("abort_addr",  imem_addr,          32'h0);
        check("abort_wdata", imem_wdata,         32'h0);
        check("abort_count", {24'd0, count},     32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        send(3'd1, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 13'd5);
        check("post_abort_addr",  imem_addr,  32'h0);
        check("post_abort_wdata", imem_wdata, 32'h00508113);
        tick();

        // END after one write.
        send(3'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
`ifdef ENCODER_HALT_WORD_EN
        check("end_we",    {31'd0, imem_we}, 32'd1);
        check("end_addr",  imem_addr,        32'h4);
        check("end_wdata", imem_wdata,       32'h00000063);
        tick();
        check("end_done",  {31'd0, done},    32'd1);
        check("end_count", {24'd0, count},   32'd2);
`else
        check("end_we",    {31'd0, imem_we}, 32'd0);
        check("end_done",  {31'd0, done},    32'd1);
        check("end_count", {24'd0, count},   32'd1);
        check("end_full",  {31'd0, full},    32'd0);
        tick();
`endif
        check("end_ready", {31'd0, req_ready}, 32'd0);
        send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 13'd0);
        check("done_absorb_we",   {31'd0, imem_we}, 32'd0);
        check("done_absorb_done", {31'd0, done},    32'd1);

        // Capacity: MAX_WORDS=2, valid held through three requests.
        @(negedge clk);
        req_kind = 3'd0; req_funct3 = 3'd0; req_funct7b5 = 1'b0;
        req_rd = 5'd3; req_rs1 = 5'd1; req_rs2 = 5'd2;
        req_valid2 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        check("cap_writes", writes2,                 32'd2);
        check("cap_count",  {24'd0, count2},         32'd2);
        check("cap_flags",  {29'd0, done2, full2, err2}, 32'b110);
        check("cap_ready",  {31'd0, req_ready2},     32'd0);
        check("cap_addr",   imem_addr2,              32'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
